// File: rtl/day05_pkg.sv
// Shared definitions for the day05 range-storage datapath: word layout and the
// sequencer state encoding, used by the parser, sequencer and search stage.
package day05_pkg;

    localparam int RANGE_W = 128;
    localparam int LO_LSB  = 0;
    localparam int LO_MSB  = 63;
    localparam int HI_LSB  = 64;
    localparam int HI_MSB  = 127;

    typedef enum logic [3:0] {
        IDLE,
        SORT_RD_A,
        SORT_RD_B,
        SORT_CMP,
        SORT_SW1,
        SORT_SW2,
        SORT_NEXT,
        MERGE_RD0,
        MERGE_RD,
        MERGE_EVAL,
        MERGE_FLUSH,
        DONE
    } seq_state_t;

    function automatic logic [63:0] range_lo(input logic [RANGE_W-1:0] w);
        return w[LO_MSB:LO_LSB];
    endfunction

    function automatic logic [63:0] range_hi(input logic [RANGE_W-1:0] w);
        return w[HI_MSB:HI_LSB];
    endfunction

endpackage

// File: rtl/day05_range_sequencer_if.sv
// Control and RAM-port bundle of the range sequencer. The slave modport is the
// sequencer itself; the master modport is the host side (control plus RAM models).
interface day05_range_sequencer_if
    import day05_pkg::*;
#(
    parameter int LOG2_MAX_RANGES = 8
);
    logic                       start;
    logic [LOG2_MAX_RANGES:0]   n_ranges;
    logic                       busy;
    logic                       done;
    logic [LOG2_MAX_RANGES-1:0] r_ram_addr;
    logic                       r_ram_we;
    logic [RANGE_W-1:0]         r_ram_wdata;
    logic [RANGE_W-1:0]         r_ram_rdata;
    logic [LOG2_MAX_RANGES-1:0] m_ram_addr;
    logic                       m_ram_we;
    logic [RANGE_W-1:0]         m_ram_wdata;
    logic [LOG2_MAX_RANGES:0]   merged_count;
    logic [63:0]                part2_result;

    modport master (
        output start, n_ranges, r_ram_rdata,
        input  busy, done, r_ram_addr, r_ram_we, r_ram_wdata,
        input  m_ram_addr, m_ram_we, m_ram_wdata, merged_count, part2_result
    );

    modport slave (
        input  start, n_ranges, r_ram_rdata,
        output busy, done, r_ram_addr, r_ram_we, r_ram_wdata,
        output m_ram_addr, m_ram_we, m_ram_wdata, merged_count, part2_result
    );
endinterface

// File: rtl/day05_range_merge_acc.sv
// Merge accumulator: holds the current merged range, tests overlap/adjacency of the
// incoming range and accumulates merged count and total covered length.
module day05_range_merge_acc
    import day05_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               eval,
    input  logic               flush,
    input  logic [RANGE_W-1:0] rdata,
    output logic               wr_en,
    output logic [RANGE_W-1:0] wr_data,
    output logic [CNT_W-1:0]   count,
    output logic [63:0]        total
);
    logic [63:0]      cur_lo_reg, cur_hi_reg, in_lo, in_hi;
    logic [CNT_W-1:0] count_reg;
    logic [63:0]      total_reg;
    logic             joinable;

    assign in_lo = range_lo(rdata);
    assign in_hi = range_hi(rdata);
    // 65-bit compare so that cur high = 2**64-1 never wraps to 0
    assign joinable = {1'b0, in_lo} <= ({1'b0, cur_hi_reg} + 65'd1);

    assign wr_en   = (eval && !joinable) || flush;
    assign wr_data = {cur_hi_reg, cur_lo_reg};
    assign count   = count_reg;
    assign total   = total_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_lo_reg <= '0;
            cur_hi_reg <= '0;
            count_reg  <= '0;
            total_reg  <= '0;
        end else begin
            if (clear) begin
                count_reg <= '0;
                total_reg <= '0;
            end else if (wr_en) begin
                count_reg <= count_reg + CNT_W'(1);
                total_reg <= total_reg + (cur_hi_reg - cur_lo_reg + 64'd1);
            end
            if (load || (eval && !joinable)) begin
                cur_lo_reg <= in_lo;
                cur_hi_reg <= in_hi;
            end else if (eval && (in_hi > cur_hi_reg)) begin
                cur_hi_reg <= in_hi;
            end
        end
    end
endmodule

// File: rtl/day05_range_sequencer.sv
// Sorts range RAM in place by (low, high) with a bubble sort, then merges into merged RAM.
// Optional DAY05_SORT_EARLY_EXIT_EN ends the sort after the first pass without a swap.
module day05_range_sequencer
    import day05_pkg::*;
#(
    parameter int MAX_RANGES      = 180,
    parameter int LOG2_MAX_RANGES = 8
) (
    input  logic clk,
    input  logic rst,
    day05_range_sequencer_if.slave ifc
);
    localparam int CNT_W = LOG2_MAX_RANGES + 1;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_RANGES);

    seq_state_t                 state_reg;
    logic                       busy_reg, done_reg, r_we_reg;
    logic [LOG2_MAX_RANGES-1:0] r_addr_reg;
    logic [RANGE_W-1:0]         r_wdata_reg, a_reg;
    logic [CNT_W-1:0]           n_reg, p_reg, j_reg, k_reg, j_inc, k_inc, n_sat;
    logic                       accept, swap_needed, pass_last, sort_finish, sort_advance, k_last;
    logic                       acc_wr_en;
    logic [RANGE_W-1:0]         acc_wr_data;
    logic [CNT_W-1:0]           acc_count;
    logic [63:0]                acc_total;

    assign n_sat  = (ifc.n_ranges > MAX_N) ? MAX_N : ifc.n_ranges;
    assign accept = ifc.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign j_inc  = j_reg + CNT_W'(1);
    assign k_inc  = k_reg + CNT_W'(1);
    assign pass_last = (j_inc == p_reg);
    assign k_last    = (k_reg == n_reg - CNT_W'(1));

    // In SORT_CMP the read data is B; A was latched the cycle before
    assign swap_needed = (range_lo(a_reg) > range_lo(ifc.r_ram_rdata)) ||
                         ((range_lo(a_reg) == range_lo(ifc.r_ram_rdata)) &&
                          (range_hi(a_reg) > range_hi(ifc.r_ram_rdata)));
    assign sort_advance = ((state_reg == SORT_CMP) && !swap_needed) || (state_reg == SORT_SW2);

`ifdef DAY05_SORT_EARLY_EXIT_EN
    logic swapped_reg;
    assign sort_finish = (p_reg == CNT_W'(1)) || !swapped_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            swapped_reg <= 1'b0;
        end else if (accept || (sort_advance && pass_last)) begin
            swapped_reg <= 1'b0;
        end else if ((state_reg == SORT_CMP) && swap_needed) begin
            swapped_reg <= 1'b1;
        end
    end
`else
    assign sort_finish = (p_reg == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            r_addr_reg  <= '0;
            r_we_reg    <= 1'b0;
            r_wdata_reg <= '0;
            a_reg       <= '0;
            n_reg       <= '0;
            p_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
        end else begin
            r_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        n_reg      <= n_sat;
                        done_reg   <= 1'b0;
                        r_addr_reg <= '0;
                        if (n_sat == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else if (n_sat == CNT_W'(1)) begin
                            busy_reg  <= 1'b1;
                            state_reg <= MERGE_RD0;
                        end else begin
                            busy_reg  <= 1'b1;
                            p_reg     <= n_sat - CNT_W'(1);
                            j_reg     <= '0;
                            state_reg <= SORT_RD_A;
                        end
                    end
                end
                SORT_RD_A: begin
                    r_addr_reg <= j_inc[LOG2_MAX_RANGES-1:0];
                    state_reg  <= SORT_RD_B;
                end
                SORT_RD_B: begin
                    a_reg     <= ifc.r_ram_rdata;
                    state_reg <= SORT_CMP;
                end
                SORT_CMP: begin
                    if (swap_needed) begin
                        r_we_reg    <= 1'b1;
                        r_addr_reg  <= j_reg[LOG2_MAX_RANGES-1:0];
                        r_wdata_reg <= ifc.r_ram_rdata;
                        state_reg   <= SORT_SW1;
                    end
                end
                SORT_SW1: begin
                    r_we_reg    <= 1'b1;
                    r_addr_reg  <= j_inc[LOG2_MAX_RANGES-1:0];
                    r_wdata_reg <= a_reg;
                    state_reg   <= SORT_SW2;
                end
                SORT_SW2: begin
                end
                SORT_NEXT: begin
                    r_addr_reg <= '0;
                    state_reg  <= MERGE_RD0;
                end
                MERGE_RD0: begin
                    r_addr_reg <= LOG2_MAX_RANGES'(1);
                    k_reg      <= CNT_W'(1);
                    state_reg  <= MERGE_RD;
                end
                MERGE_RD: begin
                    state_reg <= (n_reg == CNT_W'(1)) ? MERGE_FLUSH : MERGE_EVAL;
                end
                MERGE_EVAL: begin
                    if (k_last) begin
                        state_reg <= MERGE_FLUSH;
                    end else begin
                        k_reg      <= k_inc;
                        r_addr_reg <= k_inc[LOG2_MAX_RANGES-1:0];
                        state_reg  <= MERGE_RD;
                    end
                end
                MERGE_FLUSH: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase

            // Shared step after a compare (no swap) or after the second swap write
            if (sort_advance) begin
                if (!pass_last) begin
                    j_reg      <= j_inc;
                    r_addr_reg <= j_inc[LOG2_MAX_RANGES-1:0];
                    state_reg  <= SORT_RD_A;
                end else if (sort_finish) begin
                    state_reg <= SORT_NEXT;
                end else begin
                    p_reg      <= p_reg - CNT_W'(1);
                    j_reg      <= '0;
                    r_addr_reg <= '0;
                    state_reg  <= SORT_RD_A;
                end
            end
        end
    end

    day05_range_merge_acc #(.CNT_W(CNT_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .load    ((state_reg == MERGE_RD) && (k_reg == CNT_W'(1))),
        .eval    (state_reg == MERGE_EVAL),
        .flush   (state_reg == MERGE_FLUSH),
        .rdata   (ifc.r_ram_rdata),
        .wr_en   (acc_wr_en),
        .wr_data (acc_wr_data),
        .count   (acc_count),
        .total   (acc_total)
    );

    assign ifc.busy         = busy_reg;
    assign ifc.done         = done_reg;
    assign ifc.r_ram_addr   = r_addr_reg;
    assign ifc.r_ram_we     = r_we_reg;
    assign ifc.r_ram_wdata  = r_wdata_reg;
    assign ifc.m_ram_addr   = acc_count[LOG2_MAX_RANGES-1:0];
    assign ifc.m_ram_we     = acc_wr_en;
    assign ifc.m_ram_wdata  = acc_wr_data;
    assign ifc.merged_count = acc_count;
    assign ifc.part2_result = acc_total;
endmodule

// File: tb/tb_day05_range_sequencer.sv
// Scoreboard bench for day05_range_sequencer: expected merged words are queued at
// start and popped on each merged-RAM write.
module tb_day05_range_sequencer;
    import day05_pkg::*;

    localparam int MAX_RANGES = 180;
    localparam int LOG2       = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    day05_range_sequencer_if #(.LOG2_MAX_RANGES(LOG2)) ifc ();

    day05_range_sequencer #(.MAX_RANGES(MAX_RANGES), .LOG2_MAX_RANGES(LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    logic [127:0] r_mem [0:255];
    logic [127:0] ld    [0:255];
    logic [127:0] srt   [0:255];
    logic         load_we = 1'b0;
    logic [7:0]   load_addr = '0;
    logic [127:0] load_data = '0;

    int           errors = 0;
    int           checks = 0;
    int           busy_cnt = 0;
    int           r_we_cnt = 0;
    int           m_we_cnt = 0;
    int           last_wait = 0;
    int           exp_count = 0;
    logic [63:0]  exp_part2 = '0;
    logic [135:0] exp_q[$];
    logic [135:0] exp_w;

    always @(posedge clk) begin
        if (ifc.r_ram_we)  r_mem[ifc.r_ram_addr] <= ifc.r_ram_wdata;
        else if (load_we)  r_mem[load_addr] <= load_data;
        ifc.r_ram_rdata <= r_mem[ifc.r_ram_addr];
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ifc.busy) busy_cnt++;
            if (ifc.r_ram_we) r_we_cnt++;
            if (ifc.m_ram_we) begin
                m_we_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL m_write_extra: addr=%0d data=%h, required no write", ifc.m_ram_addr, ifc.m_ram_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({ifc.m_ram_addr, ifc.m_ram_wdata} !== exp_w) begin
                        errors++;
                        $display("FAIL m_write: got %h, required %h", {ifc.m_ram_addr, ifc.m_ram_wdata}, exp_w);
                    end
                end
                checks++;
                if (ifc.r_ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL we_overlap: r_ram_we=%b with m_ram_we, required 0", ifc.r_ram_we);
                end
            end
        end
    end

    function automatic logic [127:0] mk(input logic [63:0] lo, input logic [63:0] hi);
        return {hi, lo};
    endfunction

    function automatic bit key_gt(input logic [127:0] x, input logic [127:0] y);
        return (x[63:0] > y[63:0]) || ((x[63:0] == y[63:0]) && (x[127:64] > y[127:64]));
    endfunction

    task automatic load_ram(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            load_we = 1'b1; load_addr = 8'(i); load_data = ld[i];
        end
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    task automatic build_model(input int n);
        logic [127:0] t, cur;
        logic [63:0]  sum;
        int c, jj;
        for (int i = 0; i < n; i++) srt[i] = ld[i];
        for (int i = 1; i < n; i++) begin
            t = srt[i];
            jj = i - 1;
            while (jj >= 0 && key_gt(srt[jj], t)) begin
                srt[jj+1] = srt[jj];
                jj--;
            end
            srt[jj+1] = t;
        end
        exp_q.delete();
        c = 0; sum = '0;
        if (n > 0) begin
            cur = srt[0];
            for (int i = 1; i < n; i++) begin
                if ({1'b0, srt[i][63:0]} <= ({1'b0, cur[127:64]} + 65'd1)) begin
                    if (srt[i][127:64] > cur[127:64]) cur[127:64] = srt[i][127:64];
                end else begin
                    exp_q.push_back({8'(c), cur});
                    sum = sum + (cur[127:64] - cur[63:0] + 64'd1);
                    c++;
                    cur = srt[i];
                end
            end
            exp_q.push_back({8'(c), cur});
            sum = sum + (cur[127:64] - cur[63:0] + 64'd1);
            c++;
        end
        exp_count = c;
        exp_part2 = sum;
    endtask

    task automatic run_case(input int n_req, input int tmo, input bit poke);
        int n, bad, waited;
        n = (n_req > MAX_RANGES) ? MAX_RANGES : n_req;
        build_model(n);
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.n_ranges = 9'(n_req); busy_cnt = 0;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        checks++;
        if (ifc.busy !== (n != 0)) begin
            errors++; $display("FAIL busy_after_start: got %b, required %b", ifc.busy, (n != 0));
        end
        checks++;
        if (ifc.done !== (n == 0)) begin
            errors++; $display("FAIL done_after_start: got %b, required %b", ifc.done, (n == 0));
        end
        if (poke) begin
            repeat (5) @(posedge clk);
            #1; ifc.start = 1'b1; ifc.n_ranges = '0;
            @(posedge clk); #1; ifc.start = 1'b0; ifc.n_ranges = 9'(n_req);
        end
        waited = 0;
        while (!ifc.done && waited < tmo) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        checks++;
        if (ifc.done !== 1'b1) begin
            errors++; $display("FAIL done_timeout: done=%b after %0d cycles, required 1", ifc.done, waited);
        end
        checks++;
        if (ifc.merged_count !== 9'(exp_count)) begin
            errors++; $display("FAIL merged_count: got %0d, required %0d", ifc.merged_count, exp_count);
        end
        checks++;
        if (ifc.part2_result !== exp_part2) begin
            errors++; $display("FAIL part2: got %0d, required %0d", ifc.part2_result, exp_part2);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL m_writes_missing: %0d outstanding, required 0", exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < n; i++) if (r_mem[i] !== srt[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL range_ram_sorted: %0d entries differ, required 0", bad);
        end
        $display("run n_ranges=%0d: count=%0d part2=%0d busy_cycles=%0d", n_req, ifc.merged_count, ifc.part2_result, busy_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ifc.busy, ifc.done, ifc.r_ram_we, ifc.m_ram_we} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b, required 0000", {ifc.busy, ifc.done, ifc.r_ram_we, ifc.m_ram_we});
        end
        checks++;
        if (ifc.merged_count !== '0 || ifc.part2_result !== '0) begin
            errors++; $display("FAIL reset_results: count=%0d part2=%0d, required 0", ifc.merged_count, ifc.part2_result);
        end
        checks++;
        if (ifc.r_ram_addr !== '0 || ifc.m_ram_wdata !== '0) begin
            errors++; $display("FAIL reset_ram_ports: addr=%0d wdata=%h, required 0", ifc.r_ram_addr, ifc.m_ram_wdata);
        end
        @(negedge clk); rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_empty();
        int r0, m0;
        r0 = r_we_cnt; m0 = m_we_cnt;
        run_case(0, 10, 1'b0);
        repeat (3) @(posedge clk);
        checks++;
        if (last_wait > 2) begin
            errors++; $display("FAIL empty_latency: got %0d cycles, required <= 2", last_wait);
        end
        checks++;
        if (r_we_cnt != r0 || m_we_cnt != m0) begin
            errors++; $display("FAIL empty_writes: r=%0d m=%0d, required 0 0", r_we_cnt - r0, m_we_cnt - m0);
        end
    endtask

    task automatic test_basic();
        ld[0] = mk(3, 5); ld[1] = mk(10, 14); ld[2] = mk(16, 20); ld[3] = mk(12, 18);
        load_ram(4);
        run_case(4, 200, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd2 || ifc.part2_result !== 64'd14) begin
            errors++; $display("FAIL basic: count=%0d part2=%0d, required 2 14", ifc.merged_count, ifc.part2_result);
        end
    endtask

    task automatic test_adjacent();
        ld[0] = mk(3, 4); ld[1] = mk(1, 2);
        load_ram(2);
        run_case(2, 100, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd1 || ifc.part2_result !== 64'd4) begin
            errors++; $display("FAIL adjacent: count=%0d part2=%0d, required 1 4", ifc.merged_count, ifc.part2_result);
        end
        ld[0] = mk(7, 7); ld[1] = mk(7, 7); ld[2] = mk(7, 7);
        load_ram(3);
        run_case(3, 100, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd1 || ifc.part2_result !== 64'd1) begin
            errors++; $display("FAIL duplicates: count=%0d part2=%0d, required 1 1", ifc.merged_count, ifc.part2_result);
        end
        ld[0] = mk(42, 50);
        load_ram(1);
        run_case(1, 50, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd1 || ifc.part2_result !== 64'd9) begin
            errors++; $display("FAIL single: count=%0d part2=%0d, required 1 9", ifc.merged_count, ifc.part2_result);
        end
    endtask

    task automatic test_wrap();
        ld[0] = mk(64'd0, 64'hFFFF_FFFF_FFFF_FFFF); ld[1] = mk(5, 9);
        load_ram(2);
        run_case(2, 100, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd1 || ifc.part2_result !== 64'd0) begin
            errors++; $display("FAIL wrap_full: count=%0d part2=%0d, required 1 0", ifc.merged_count, ifc.part2_result);
        end
        ld[0] = mk(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF); ld[1] = mk(1, 1);
        load_ram(2);
        run_case(2, 100, 1'b0);
        checks++;
        if (ifc.merged_count !== 9'd2 || ifc.part2_result !== 64'd3) begin
            errors++; $display("FAIL wrap_top: count=%0d part2=%0d, required 2 3", ifc.merged_count, ifc.part2_result);
        end
    endtask

    task automatic test_large();
        for (int i = 0; i < 200; i++) begin
            ld[i] = mk(64'h1234_0000_0000 + 64'((179 - i) * 10),
                       64'h1234_0000_0000 + 64'((179 - i) * 10) + ((i % 4 == 0) ? 64'd15 : 64'd3));
        end
        load_ram(200);
        run_case(200, 90000, 1'b0);
`ifdef DAY05_SORT_EARLY_EXIT_EN
        for (int i = 0; i < 180; i++) ld[i] = mk(64'(i * 10), 64'(i * 10 + 3));
        load_ram(180);
        run_case(180, 5000, 1'b0);
        // one pass of 179 compares, then SORT_NEXT, RD0, 179 x (RD,EVAL), FLUSH
        checks++;
        if (busy_cnt != 179 * 3 + 2 + 2 * 179 + 1) begin
            errors++; $display("FAIL early_exit_cycles: got %0d busy cycles, required %0d", busy_cnt, 179 * 3 + 2 + 2 * 179 + 1);
        end
`endif
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 10; i++) ld[i] = mk(64'((9 - i) * 4), 64'((9 - i) * 4 + ((i % 2 == 0) ? 5 : 1)));
        load_ram(10);
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.n_ranges = 9'd10;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ifc.busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before: got %b, required 1", ifc.busy);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ifc.busy, ifc.done, ifc.r_ram_we, ifc.m_ram_we} !== 4'b0) begin
            errors++; $display("FAIL abort_flags: got %b, required 0000", {ifc.busy, ifc.done, ifc.r_ram_we, ifc.m_ram_we});
        end
        checks++;
        if (ifc.merged_count !== '0 || ifc.part2_result !== '0) begin
            errors++; $display("FAIL abort_results: count=%0d part2=%0d, required 0", ifc.merged_count, ifc.part2_result);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        load_ram(10);
        run_case(10, 2000, 1'b1);
    endtask

    initial begin
        ifc.start    = 1'b0;
        ifc.n_ranges = '0;
        test_reset();
        test_empty();
        test_basic();
        test_adjacent();
        test_wrap();
        test_reset_abort();
        test_large();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
